// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data load/store; data has fixed priority.
// Define MEMORY_ARBITER_STARVE_GUARD_EN to force a fetch after STARVE_LIMIT data grants taken while a fetch waits.
module memory_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t state, next_state;
    logic   dreq;
    logic   access;
    logic   istarved;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RAM_ACCESS);

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Counts data grants that jumped a waiting fetch; only IDLE cycles can grant.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!iREN || next_state == IACC) begin
                starve_cnt <= '0;
            end else if (next_state == DACC && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign istarved = iREN && (starve_cnt == CNT_MAX);
`else
    // The limit only matters with the guard; it folds to a constant zero here.
    assign istarved = iREN & (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (istarved) begin
                    next_state = IACC;
                end else if (dreq) begin
                    next_state = DACC;
                end else if (iREN) begin
                    next_state = IACC;
                end
            end
            DACC: begin
                if (!dreq || access) begin
                    next_state = IDLE;
                end
            end
            IACC: begin
                if (!iREN || access) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A dropped request removes its enables at once, so an aborted access never completes.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state)
            DACC: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else if (dREN) begin
                    ramREN = 1'b1;
                end
                if (dreq && access) begin
                    dwait = 1'b0;
                    if (!dWEN) begin
                        dload = ramload;
                    end
                end
            end
            IACC: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iREN && access) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Arbitrates the single-ported RAM between the instruction-fetch path and the data load/store path of the pipelined datapath.
- Registered FSM grants one requester per transaction, drives the RAM control/address/data, and returns completion (wait deassert) plus load data.
- Data requests have fixed priority over instruction requests, with an optional anti-starvation guard for instruction fetch.

Parameters:
- WORD_W, 32, width of address and data words.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before a fetch is forced (used only with the optional feature).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  1  instruction read request.
- iaddr  input  WORD_W  instruction address.
- iwait  output  1  0 = instruction transaction completes this cycle.
- iload  output  WORD_W  instruction read data.
- dREN  input  1  data read request.
- dWEN  input  1  data write request.
- daddr  input  WORD_W  data address.
- dstore  input  WORD_W  data write value.
- dwait  output  1  0 = data transaction completes this cycle.
- dload  output  WORD_W  data read data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  WORD_W  RAM address.
- ramstore  output  WORD_W  RAM write data.
- ramload  input  WORD_W  RAM read data.
- ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (nRST=0, async): state IDLE, starvation counter 0; ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- FSM states: IDLE, DACC, IACC.
- IDLE:
  - All RAM enables are 0; both waits are 1.
  - On the next edge, go to DACC if (dREN|dWEN), else IACC if iREN, else stay in IDLE.
- DACC:
  - ramaddr=daddr (combinational pass-through).
  - If dWEN=1: ramWEN=1, ramstore=dstore. dWEN wins when dREN and dWEN are both 1.
  - Otherwise ramREN=1.
- IACC: ramREN=1, ramaddr=iaddr.
- Completion:
  - When ramstate==ACCESS in DACC or IACC, the granted wait goes 0 that same cycle (combinational).
  - For reads, dload/iload=ramload that cycle.
  - FSM returns to IDLE on the next edge.
- The non-granted wait is always 1. Load outputs are 0 when not completing.
- Stall: ramstate BUSY or FREE keeps the current state with outputs held.
- Error: ramstate ERROR keeps the state. The access is retried and wait is never deasserted on ERROR.
- Abort: if the granted requester drops its enable mid-transaction (DACC with dREN=dWEN=0, or IACC with iREN=0):
  - RAM enables drop combinationally that cycle.
  - Return to IDLE next edge with no completion.
- Minimum latency: request seen in IDLE at edge t, grant state at t+1, completion in the first cycle of ACCESS.
- Back-to-back transactions always pass through one IDLE cycle, so the minimum spacing is 2 cycles.
- Simultaneous iREN and dREN/dWEN in IDLE: data wins (subject to the optional feature). iREN remains pending and is granted after the data transaction.
- Address/data are not latched. Requesters hold iaddr/daddr/dstore stable until their wait is 0.

Optional Feature:
- Macro: MEMORY_ARBITER_STARVE_GUARD_EN.
- Enabled:
  - A counter increments on each data grant (IDLE->DACC) taken while iREN=1.
  - The counter clears on any IACC grant, or on an IDLE cycle with iREN=0.
  - When the counter equals STARVE_LIMIT and iREN=1 in IDLE, IACC is granted even if a data request is present.
  - The counter saturates at STARVE_LIMIT.
- Disabled: no counter; strict data priority.

Test Plan:
- Reset mid-DACC write (ramWEN=1), pulse nRST low -> ramWEN=0, ramREN=0, iwait=dwait=1 immediately; IDLE after release.
- iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C220004 in cycle 3 only.
- iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF -> DACC first: ramWEN=1, ramstore=0xDEADBEEF, dwait=0 on ACCESS. Then IDLE, then IACC completes the fetch.
- DACC with ramstate=ERROR 3 cycles then ACCESS -> dwait stays 1 during ERROR, RAM signals held; dwait=0 on ACCESS.
- dREN dropped in DACC before ACCESS -> ramREN=0 that cycle, dwait never 0, IDLE next edge.
- With MEMORY_ARBITER_STARVE_GUARD_EN, STARVE_LIMIT=4, iREN held, dREN reasserted every IDLE -> 4 data completions, then IACC granted; counter resets. Without the macro, iREN is never granted during this sequence.
